// File: rtl/hw_enc_driver.sv
// Avalon-MM master for the hw_imp encryptor: writes one plaintext/key job as
// eight 32-bit words, reads back four ciphertext words, streams the result out.
module hw_enc_driver #(
   parameter int   DATA_W         = 32,
   parameter logic WR_ADDR        = 1'b1,
   parameter logic RD_ADDR        = 1'b0,
   parameter int   TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [127:0]      in_block,
   input  logic [127:0]      in_key,
   output logic              m_address,
   output logic              m_write,
   output logic [DATA_W-1:0] m_writedata,
   output logic              m_read,
   input  logic [DATA_W-1:0] m_readdata,
   input  logic              m_waitrequest,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [127:0]      out_block,
   output logic              busy,
   output logic              timeout_err
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] WR_PT  = 3'd1;
   localparam logic [2:0] WR_KEY = 3'd2;
   localparam logic [2:0] RD_CT  = 3'd3;
   localparam logic [2:0] OUT    = 3'd4;

   localparam int                TCNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

   logic [2:0]             state;
   logic [1:0]             idx;
   logic [TCNT_W-1:0]      tcnt;
   logic [7:0][DATA_W-1:0] job_q;
   logic [3:0][DATA_W-1:0] ct_q;
   logic [2:0]             word_sel;
   logic [2:0]             next_sel;
   logic                   stalled;
   logic                   timed_out;

   // Plaintext words are job words 0-3 and key words are 4-7, so one counter walks both.
   assign word_sel  = {state == WR_KEY, idx};
   assign next_sel  = word_sel + 3'd1;
   assign stalled   = (m_write | m_read) & m_waitrequest;
   assign timed_out = stalled && (tcnt == TCNT_LAST);

   assign in_ready  = reset && (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_block = ct_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         idx         <= '0;
         tcnt        <= '0;
         job_q       <= '0;
         ct_q        <= '0;
         m_address   <= 1'b0;
         m_write     <= 1'b0;
         m_writedata <= '0;
         m_read      <= 1'b0;
         out_valid   <= 1'b0;
         timeout_err <= 1'b0;
      end else if (timed_out) begin
         state       <= IDLE;
         idx         <= '0;
         tcnt        <= '0;
         m_write     <= 1'b0;
         m_read      <= 1'b0;
         m_writedata <= '0;
         timeout_err <= 1'b1;
      end else if (stalled) begin
         tcnt <= tcnt + 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  job_q <= {in_key, in_block};
                  idx   <= '0;
                  tcnt  <= '0;
                  state <= WR_PT;
               end
            end
            WR_PT, WR_KEY: begin
               // Strobe held across word boundaries so completed words go out back to back.
               if (!m_write) begin
                  m_write     <= 1'b1;
                  m_address   <= WR_ADDR;
                  m_writedata <= job_q[word_sel];
               end else begin
                  tcnt <= '0;
                  idx  <= idx + 1'b1;
                  if (word_sel == 3'd7) begin
                     state       <= RD_CT;
                     m_write     <= 1'b0;
                     m_writedata <= '0;
                  end else begin
                     m_writedata <= job_q[next_sel];
                     if (idx == 2'd3) begin
                        state <= WR_KEY;
                     end
                  end
               end
            end
            RD_CT: begin
               if (!m_read) begin
                  m_read    <= 1'b1;
                  m_address <= RD_ADDR;
               end else begin
                  ct_q[idx] <= m_readdata;
                  idx       <= idx + 1'b1;
                  tcnt      <= '0;
                  if (idx == 2'd3) begin
                     m_read    <= 1'b0;
                     state     <= OUT;
                     out_valid <= 1'b1;
                  end
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/hw_enc_driver.md
Name: hw_enc_driver

Overview:
- Upstream master stage for the hw_imp encryption slave.
- Accepts one 128-bit plaintext block and one 128-bit key on a valid/ready input stream, and serialises them into eight 32-bit Avalon-MM writes.
- Then issues four Avalon-MM reads to collect the 128-bit ciphertext and presents it on a valid/ready output stream.
- Lets a streaming producer or DMA drive the encryptor without software sequencing.

Parameters:
- DATA_W, 32, Avalon data width. Fixed at 32; other values are unsupported.
- WR_ADDR, 1'b1, address used for plaintext and key writes.
- RD_ADDR, 1'b0, address used for ciphertext reads.
- TIMEOUT_CYCLES, 1024, number of consecutive waitrequest-high cycles allowed in one bus transfer before it is abandoned. Minimum value is 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_block and in_key are valid.
- in_ready  out  1  block can accept a job.
- in_block  in  128  plaintext; word0 = bits[31:0].
- in_key  in  128  key; word0 = bits[31:0].
- m_address  out  1  Avalon address.
- m_write  out  1  Avalon write strobe.
- m_writedata  out  32  Avalon write data.
- m_read  out  1  Avalon read strobe.
- m_readdata  in  32  Avalon read data (zero latency).
- m_waitrequest  in  1  slave stall.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer accepts ciphertext.
- out_block  out  128  ciphertext; word0 = bits[31:0].
- busy  out  1  a job is in progress (state is not IDLE).
- timeout_err  out  1  sticky flag: a transfer timed out.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, word index=0, timeout counter=0.
  - m_write=0, m_read=0, m_address=0, m_writedata=0.
  - out_valid=0, out_block=0, busy=0, timeout_err=0.
  - in_ready=1 once reset is released.
  - A reset during a job aborts it immediately; partial data is discarded.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_block and in_key into internal 256-bit registers, set index=0, go to WR_PT.
  - in_ready=0 in every state other than IDLE.
- WR_PT:
  - m_write=1, m_address=WR_ADDR, m_writedata=plaintext word[index].
  - A transfer completes on a cycle with m_write=1 and m_waitrequest=0.
  - On completion, index increments. After word 3, reset index to 0 and go to WR_KEY.
  - Address, data and strobe are held stable while m_waitrequest=1.
  - Back-to-back words: the next word is driven on the cycle after completion with no idle gap, so a no-stall slave sees 8 writes on 8 consecutive cycles.
- WR_KEY:
  - Same as WR_PT, using key word[index].
  - After key word 3, drop m_write, set index=0 and go to RD_CT.
- RD_CT:
  - m_read=1, m_address=RD_ADDR.
  - On a cycle with m_read=1 and m_waitrequest=0, capture m_readdata into out_block word[index] and increment index.
  - After word 3, drop m_read and go to OUT.
  - The slave holds waitrequest until the result is ready; the driver does not poll status.
- OUT:
  - out_valid=1; out_block is stable until accepted.
  - On out_ready=1, clear out_valid and go to IDLE; in_ready=1 on the following cycle.
- Timeout:
  - The counter increments each cycle a strobe is high with m_waitrequest=1.
  - It clears on every completed transfer and on every state change.
  - When the counter reaches TIMEOUT_CYCLES: drop both strobes, set timeout_err=1, discard the job and go to IDLE.
  - timeout_err stays set until reset; later jobs still run.
- Invariants:
  - m_write and m_read are never both high.
  - out_valid and in_ready are never both high.
  - m_writedata is 0 whenever m_write=0.
  - Latency with no stalls: 8 write cycles, then 4 read cycles, then out_valid on the next cycle. The minimum job is 14 cycles from input accept to out_valid.

Test Plan:
- Basic job, no stalls:
  - Stimulus: in_block=0x98765432_10fedcba_77665544_33221100, in_key=0x12345678_9abcdef0_aabbccdd_eeff0011, slave never stalls, read data 0xA0, 0xA1, 0xA2, 0xA3.
  - Required: writes at address 1 in the order 33221100, 77665544, 10fedcba, 98765432, eeff0011, aabbccdd, 9abcdef0, 12345678; then 4 reads at address 0; out_block=0x000000A3_000000A2_000000A1_000000A0; out_valid rises 14 cycles after accept.
- Write stall:
  - Stimulus: waitrequest held high for 3 cycles on key word 1.
  - Required: m_writedata holds 0xaabbccdd and m_write holds 1 for all stalled cycles; each of the eight words is written exactly once.
- Read stall (slave computing):
  - Stimulus: waitrequest high for 40 cycles on the first read.
  - Required: m_read stays high throughout; out_block is correct; timeout_err=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, waitrequest stuck high on plaintext word 2.
  - Required: at cycle 16 both strobes drop, timeout_err=1, state returns to IDLE with in_ready=1; a following job with no stalls completes correctly and timeout_err stays 1.
- Output backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid rises.
  - Required: out_valid and out_block are stable, in_ready=0, no bus activity; in_ready=1 on the cycle after the out_ready handshake.
- Reset mid-job:
  - Stimulus: assert reset during RD_CT word 1.
  - Required: all outputs take their reset values immediately; after release, a new job runs clean from plaintext word 0.
